// File: rtl/fir_pkg.sv
// Shared types and index helpers for the FIR sequencer.
// Indices are 4-bit and always kept within 0..TAP_NUM-1.
package fir_pkg;

  localparam int TAP_NUM = 11;
  localparam int IDX_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT_IN,
    MAC,
    DRAIN,
    OUT,
    DONE
  } state_t;

  // (a - b) mod TAP_NUM, both operands already in range
  function automatic logic [IDX_W-1:0] idx_sub(
    input logic [IDX_W-1:0] a,
    input logic [IDX_W-1:0] b
  );
    logic [IDX_W:0] t;
    t = {1'b0, a} + 5'(TAP_NUM) - {1'b0, b};
    if (t >= 5'(TAP_NUM)) t = t - 5'(TAP_NUM);
    return t[IDX_W-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] idx_inc(
    input logic [IDX_W-1:0] a
  );
    if (a == 4'(TAP_NUM - 1)) return '0;
    return a + 4'd1;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Registered multiply-accumulate: acc += tap*data, 32-bit wrap.
// Clear has priority; one-cycle latency from operands to acc.
module fir_mac_unit #(
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clr,
  input  logic                i_en,
  input  logic signed [W-1:0] i_tap,
  input  logic signed [W-1:0] i_data,
  output logic [W-1:0]        o_acc
);

  logic signed [W-1:0] w_prod;
  logic [W-1:0]        r_acc;

  // product evaluated in W-bit context keeps only the low W bits
  assign w_prod = i_tap * i_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR run sequencer: clears the data ring, takes samples over
// AXI-Stream, runs an 11-tap MAC per sample and streams results.
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   ap_start,
  input  logic [31:0]            data_length,
  output logic                   ap_idle,
  output logic                   ap_done,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  input  logic                   sm_tready,
  output logic                   tap_EN,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic [3:0]             data_WE,
  output logic                   data_EN,
  output logic [pDATA_WIDTH-1:0] data_Di,
  output logic [pADDR_WIDTH-1:0] data_A,
  input  logic [pDATA_WIDTH-1:0] data_Do
);

  localparam logic [IDX_W-1:0] LAST_IDX = 4'(Tape_Num - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [31:0]      r_cnt;
  logic [31:0]      w_cnt_nxt;
  logic [31:0]      r_len;
  logic [31:0]      w_len_nxt;
  logic             r_done;
  logic             w_done_nxt;

  logic                   w_ss_tready;
  logic                   w_tap_en;
  logic                   w_data_en;
  logic                   w_data_we;
  logic [IDX_W-1:0]       w_data_idx;
  logic [pDATA_WIDTH-1:0] w_data_di;
  logic                   w_mac_clr;
  logic                   w_mac_en;
  logic                   w_last;
  logic [pDATA_WIDTH-1:0] w_acc;
  logic                   w_unused;

  // stream framing comes from the sample count, not from tlast
  assign w_unused = ss_tlast;

  assign w_last = (r_cnt + 32'd1) == r_len;

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_done_nxt  = r_done;
    w_ss_tready = 1'b0;
    w_tap_en    = 1'b0;
    w_data_en   = 1'b0;
    w_data_we   = 1'b0;
    w_data_idx  = r_ptr;
    w_data_di   = '0;
    w_mac_clr   = 1'b0;
    w_mac_en    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (ap_start) begin
          w_state_nxt = CLEAR;
          w_done_nxt  = 1'b0;
          w_len_nxt   = data_length;
          w_idx_nxt   = '0;
        end
      end
      CLEAR: begin
        w_data_en  = 1'b1;
        w_data_we  = 1'b1;
        w_data_idx = r_idx;
        if (r_idx == LAST_IDX) begin
          w_idx_nxt = '0;
          w_ptr_nxt = '0;
          w_cnt_nxt = '0;
          if (r_len == 32'd0) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = WAIT_IN;
          end
        end else begin
          w_idx_nxt = r_idx + 4'd1;
        end
      end
      WAIT_IN: begin
        w_ss_tready = 1'b1;
        if (ss_tvalid) begin
          w_data_en   = 1'b1;
          w_data_we   = 1'b1;
          w_data_di   = ss_tdata;
          w_mac_clr   = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = MAC;
        end
      end
      MAC: begin
        w_tap_en   = 1'b1;
        w_data_en  = 1'b1;
        w_data_idx = idx_sub(r_ptr, r_idx);
        // read data lands one cycle after issue
        w_mac_en   = (r_idx != '0);
        if (r_idx == LAST_IDX) begin
          w_idx_nxt   = '0;
          w_state_nxt = DRAIN;
        end else begin
          w_idx_nxt = r_idx + 4'd1;
        end
      end
      DRAIN: begin
        w_mac_en    = 1'b1;
        w_state_nxt = OUT;
      end
      OUT: begin
        if (sm_tready) begin
          w_cnt_nxt = r_cnt + 32'd1;
          w_ptr_nxt = idx_inc(r_ptr);
          if (w_last) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = WAIT_IN;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  fir_mac_unit #(
    .W (pDATA_WIDTH)
  ) u_mac (
    .clk    (axis_clk),
    .rst_n  (axis_rst_n),
    .i_clr  (w_mac_clr),
    .i_en   (w_mac_en),
    .i_tap  (tap_Do),
    .i_data (data_Do),
    .o_acc  (w_acc)
  );

  assign ap_idle   = (r_state == IDLE);
  assign ap_done   = r_done;
  assign ss_tready = w_ss_tready;

  assign sm_tvalid = (r_state == OUT);
  assign sm_tdata  = sm_tvalid ? w_acc : '0;
  assign sm_tlast  = sm_tvalid & w_last;

  assign tap_EN  = w_tap_en;
  assign tap_A   = w_tap_en ?
                   {{(pADDR_WIDTH-6){1'b0}}, r_idx, 2'b00} : '0;
  assign data_EN = w_data_en;
  assign data_WE = w_data_we ? 4'hF : 4'h0;
  assign data_Di = w_data_di;
  assign data_A  = w_data_en ?
                   {{(pADDR_WIDTH-6){1'b0}}, w_data_idx, 2'b00} : '0;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl with behavioural BRAM models
// and hand-computed expected outputs.
module tb_fir_seq_ctrl;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n = 1'b0;
  logic        ap_start = 1'b0;
  logic [31:0] data_length = '0;
  logic        ap_idle;
  logic        ap_done;
  logic        ss_tvalid = 1'b0;
  logic [31:0] ss_tdata = '0;
  logic        ss_tlast = 1'b0;
  logic        ss_tready;
  logic        sm_tvalid;
  logic [31:0] sm_tdata;
  logic        sm_tlast;
  logic        sm_tready = 1'b1;
  logic        tap_EN;
  logic [11:0] tap_A;
  logic [31:0] tap_Do = '0;
  logic [3:0]  data_WE;
  logic        data_EN;
  logic [31:0] data_Di;
  logic [11:0] data_A;
  logic [31:0] data_Do = '0;

  always #5 axis_clk = ~axis_clk;

  fir_seq_ctrl dut (
    .axis_clk    (axis_clk),
    .axis_rst_n  (axis_rst_n),
    .ap_start    (ap_start),
    .data_length (data_length),
    .ap_idle     (ap_idle),
    .ap_done     (ap_done),
    .ss_tvalid   (ss_tvalid),
    .ss_tdata    (ss_tdata),
    .ss_tlast    (ss_tlast),
    .ss_tready   (ss_tready),
    .sm_tvalid   (sm_tvalid),
    .sm_tdata    (sm_tdata),
    .sm_tlast    (sm_tlast),
    .sm_tready   (sm_tready),
    .tap_EN      (tap_EN),
    .tap_A       (tap_A),
    .tap_Do      (tap_Do),
    .data_WE     (data_WE),
    .data_EN     (data_EN),
    .data_Di     (data_Di),
    .data_A      (data_A),
    .data_Do     (data_Do)
  );

  logic [31:0] tmem [0:10];
  logic [31:0] dmem [0:10];

  int n_chk = 0;
  int n_err = 0;
  int n_wr = 0;
  int n_zero = 0;
  int n_rdy = 0;
  int n_tap = 0;
  int n_bad = 0;
  int lat = 0;

  always @(posedge axis_clk) begin
    if (tap_EN) begin
      n_tap++;
      if (tap_A >= 12'd44 || tap_A[1:0] != 2'b00) n_bad++;
      else tap_Do <= tmem[tap_A[5:2]];
    end
    if (data_EN) begin
      if (data_A >= 12'd44 || data_A[1:0] != 2'b00) begin
        n_bad++;
      end else begin
        if (data_WE == 4'hF) begin
          dmem[data_A[5:2]] <= data_Di;
          n_wr++;
          if (data_Di == 32'd0) n_zero++;
        end
        data_Do <= dmem[data_A[5:2]];
      end
    end
    if (ss_tready) n_rdy++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d",
               tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic set_taps(input bit ramp);
    for (int i = 0; i < 11; i++)
      tmem[i] = ramp ? 32'(i + 1) : ((i == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic start_run(input logic [31:0] len);
    @(negedge axis_clk);
    ap_start = 1'b1;
    data_length = len;
    @(negedge axis_clk);
    ap_start = 1'b0;
    data_length = 32'hFFFF_FFFF;
  endtask

  task automatic send(input logic [31:0] v, input string tag);
    int t = 0;
    ss_tdata = v;
    ss_tvalid = 1'b1;
    while (!ss_tready && t < 100) begin
      @(negedge axis_clk);
      t++;
    end
    if (!ss_tready) begin
      check({tag, "_rdy_timeout"}, 32'd0, 32'd1);
      ss_tvalid = 1'b0;
      return;
    end
    @(posedge axis_clk);
    #1 ss_tvalid = 1'b0;
    @(negedge axis_clk);
  endtask

  task automatic recv(input logic [31:0] exp, input logic exp_last,
                      input int stall, input string tag);
    int t = 0;
    while (!sm_tvalid && t < 100) begin
      @(negedge axis_clk);
      t++;
    end
    if (!sm_tvalid) begin
      check({tag, "_vld_timeout"}, 32'd0, 32'd1);
      return;
    end
    lat = t + 1;
    check({tag, "_data"}, sm_tdata, exp);
    check({tag, "_last"}, 32'(sm_tlast), 32'(exp_last));
    if (stall > 0) begin
      sm_tready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        @(negedge axis_clk);
        check($sformatf("%s_hold_data%0d", tag, i), sm_tdata, exp);
        check($sformatf("%s_hold_vld%0d", tag, i), 32'(sm_tvalid), 32'd1);
        check($sformatf("%s_hold_rdy%0d", tag, i), 32'(ss_tready), 32'd0);
      end
      sm_tready = 1'b1;
    end
    @(posedge axis_clk);
    @(negedge axis_clk);
  endtask

  int exp2 [12] = '{1, 3, 6, 10, 15, 21, 28, 36, 45, 55, 66, 66};
  int in1 [5] = '{3, -4, 5, 6, 7};
  int tap0, wr0, zero0, rdy0, t;

  initial begin
    set_taps(1'b0);
    repeat (2) @(posedge axis_clk);
    @(negedge axis_clk);
    check("rst_idle", 32'(ap_idle), 32'd1);
    check("rst_done", 32'(ap_done), 32'd0);
    check("rst_ssrdy", 32'(ss_tready), 32'd0);
    check("rst_smvld", 32'(sm_tvalid), 32'd0);
    check("rst_smdata", sm_tdata, 32'd0);
    check("rst_en", 32'({tap_EN, data_EN, data_WE}), 32'd0);
    axis_rst_n = 1'b1;

    // identity taps: output equals input
    tap0 = n_tap;
    start_run(32'd5);
    check("t1_busy", 32'(ap_idle), 32'd0);
    for (int i = 0; i < 5; i++) begin
      send(32'(in1[i]), "t1");
      recv(32'(in1[i]), i == 4, 0, $sformatf("t1_o%0d", i));
      if (i == 0) check("t1_latency", 32'(lat), 32'd13);
    end
    check("t1_done", 32'(ap_done), 32'd1);
    check("t1_tapcyc", 32'(n_tap - tap0), 32'd55);
    @(negedge axis_clk);
    check("t1_idle", 32'(ap_idle), 32'd1);
    check("t1_done_idle", 32'(ap_done), 32'd1);

    // ramp taps, all-ones input, pointer wraps
    set_taps(1'b1);
    start_run(32'd12);
    for (int i = 0; i < 12; i++) begin
      send(32'd1, "t2");
      recv(32'(exp2[i]), i == 11, 0, $sformatf("t2_o%0d", i));
    end
    check("t2_done", 32'(ap_done), 32'd1);

    // second run must not see old samples
    start_run(32'd1);
    check("t5_done_clr", 32'(ap_done), 32'd0);
    send(32'd5, "t5");
    recv(32'd5, 1'b1, 0, "t5_o0");
    check("t5_done", 32'(ap_done), 32'd1);

    // output back-pressure
    set_taps(1'b0);
    start_run(32'd2);
    send(32'd10, "t3");
    recv(32'd10, 1'b0, 7, "t3_o0");
    send(32'd20, "t3");
    recv(32'd20, 1'b1, 0, "t3_o1");

    // zero-length run
    wr0 = n_wr;
    zero0 = n_zero;
    rdy0 = n_rdy;
    start_run(32'd0);
    t = 0;
    while (!ap_done && t < 100) begin
      @(negedge axis_clk);
      t++;
    end
    check("t4_done", 32'(ap_done), 32'd1);
    check("t4_writes", 32'(n_wr - wr0), 32'd11);
    check("t4_zeros", 32'(n_zero - zero0), 32'd11);
    check("t4_noready", 32'(n_rdy - rdy0), 32'd0);

    // reset in the middle of a MAC sweep
    set_taps(1'b1);
    start_run(32'd3);
    send(32'd4, "t6");
    repeat (4) @(negedge axis_clk);
    check("t6_inmac", 32'(tap_EN), 32'd1);
    axis_rst_n = 1'b0;
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    check("t6_idle", 32'(ap_idle), 32'd1);
    check("t6_smvld", 32'(sm_tvalid), 32'd0);
    check("t6_en", 32'({tap_EN, data_EN}), 32'd0);
    check("t6_done", 32'(ap_done), 32'd0);
    start_run(32'd2);
    send(32'd2, "t6b");
    recv(32'd2, 1'b0, 0, "t6_o0");
    send(32'd3, "t6b");
    recv(32'd7, 1'b1, 0, "t6_o1");
    check("t6_done2", 32'(ap_done), 32'd1);

    check("addr_range", 32'(n_bad), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
